// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage definitions: machine width, reset PC default, NOP encoding,
// and the byte-swap helper used on little-endian instruction memories.
package fetch_queue_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    function automatic logic [XLEN-1:0] bswap32(input logic [XLEN-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register queue of {pc, ir} entries; the head sits in entry 0 so the
// outputs come straight from flops. Flush empties it in one edge.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_ir,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_ir
);

    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] ir_q [DEPTH];
    logic [CW-1:0]   count_q;
    logic            pop_ok;
    logic            push_ok;
    logic [CW-1:0]   wr_idx;

    assign pop_ok  = pop && (count_q != '0);
    // A simultaneous pop frees a slot, so the write lands one position lower.
    assign wr_idx  = count_q - CW'(pop_ok);
    assign push_ok = push && (wr_idx < CW'(DEPTH));

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                ir_q[i] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_q[i] <= pc_q[i+1];
                    ir_q[i] <= ir_q[i+1];
                end
            end
            if (push_ok) begin
                pc_q[wr_idx[CW-2:0]] <= push_pc;
                ir_q[wr_idx[CW-2:0]] <= push_ir;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign head_pc = pc_q[0];
    assign head_ir = ir_q[0];

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && !flush && !push_ok));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues one word read per cycle while
// the queue has room, buffers responses and presents them to decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          DEPTH      = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_RE,
    output logic [29:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        ID_READY,
    output logic        IF_VALID,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_IR
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [31:0]   rdata_ir;

    assign pop       = IF_VALID & ID_READY;
    // Slots already committed (queued or in flight) after this cycle's pop.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = RSTN & ~REDIRECT & (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight & ~REDIRECT;
    assign rdata_ir  = BIG_ENDIAN ? IMEM_RDATA : bswap32(IMEM_RDATA);

    assign IMEM_RE   = issue;
    assign IMEM_ADDR = fetch_pc[31:2];
    assign IF_VALID  = ~empty;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (REDIRECT) begin
            fetch_pc <= REDIRECT_PC & ~32'd3;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .push    (push),
        .push_pc (inflight_pc),
        .push_ir (rdata_ir),
        .pop     (pop),
        .flush   (REDIRECT),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .head_pc (IF_PC),
        .head_ir (IF_IR)
    );

    a_full_needs_pop: assert property (@(posedge CLK) disable iff (!RSTN)
        full |-> (!IMEM_RE || pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset/latency/stall/redirect vector table, directed reset,
// wrap and endianness sequences, then random traffic against a queue-based model.
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IMEM_RE;
    logic [29:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = '0;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        ID_READY;
    logic        IF_VALID;
    logic [31:0] IF_PC;
    logic [31:0] IF_IR;

    logic        be_re;
    logic [29:0] be_addr;
    logic        be_valid;
    logic [31:0] be_pc;
    logic [31:0] be_ir;

    always #5 CLK = ~CLK;

    fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut (
        .CLK(CLK), .RSTN(RSTN), .IMEM_RE(IMEM_RE), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RDATA(IMEM_RDATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .ID_READY(ID_READY), .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_IR(IF_IR)
    );

    fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
        .CLK(CLK), .RSTN(RSTN), .IMEM_RE(be_re), .IMEM_ADDR(be_addr),
        .IMEM_RDATA(IMEM_RDATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .ID_READY(ID_READY), .IF_VALID(be_valid), .IF_PC(be_pc), .IF_IR(be_ir)
    );

    logic mem_const = 1'b0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return mem_const ? 32'h1234_5678 : {2'b00, a};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(posedge CLK) if (IMEM_RE) IMEM_RDATA <= mem_word(IMEM_ADDR);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic        m_infl = 1'b0;
    ent_t        m_ie;
    logic [31:0] m_fpc = RST_PC;
    logic        exp_pop, exp_re, exp_valid;
    logic [31:0] sb_next = RST_PC;
    logic        cur_rstn, cur_redir, cur_rdy;
    logic [31:0] cur_rpc;

    task automatic apply(input logic rstn, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
        RSTN = rstn; REDIRECT = redir; REDIRECT_PC = rpc; ID_READY = rdy;
        cur_rstn = rstn; cur_redir = redir; cur_rpc = rpc; cur_rdy = rdy;
        #2;
    endtask

    task automatic model_check();
        exp_valid = (mq.size() != 0);
        exp_pop   = exp_valid && cur_rdy;
        exp_re    = cur_rstn && !cur_redir &&
                    ((mq.size() + int'(m_infl) - int'(exp_pop)) < DEPTH);
        check("m_re", 32'(IMEM_RE), 32'(exp_re));
        check("m_addr", 32'(IMEM_ADDR), 32'(m_fpc[31:2]));
        check("m_valid", 32'(IF_VALID), 32'(exp_valid));
        check("m_be_valid", 32'(be_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("m_pc", IF_PC, mq[0].pc);
            check("m_ir", IF_IR, mq[0].ir);
            check("m_be_ir", be_ir, swap32(mq[0].ir));
        end
    endtask

    task automatic advance();
        if (cur_rstn && exp_pop) begin
            check("stream_pc", IF_PC, sb_next);
            sb_next = sb_next + 32'd4;
        end
        if (!cur_rstn)      sb_next = RST_PC;
        else if (cur_redir) sb_next = cur_rpc & ~32'd3;

        if (!cur_rstn) begin
            mq.delete(); m_infl = 1'b0; m_fpc = RST_PC;
        end else if (cur_redir) begin
            mq.delete(); m_infl = 1'b0; m_fpc = cur_rpc & ~32'd3;
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_ie);
            if (exp_re) begin
                m_infl = 1'b1;
                m_ie   = '{pc: m_fpc, ir: swap32(mem_word(m_fpc[31:2]))};
                m_fpc  = m_fpc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input logic rstn, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
        apply(rstn, redir, rpc, rdy);
        model_check();
        advance();
    endtask

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_re;
        logic [29:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [0:16];

    initial begin
        logic [31:0] got[$];
        logic [31:0] wrap_exp [4];

        // cycles 1..17 after reset release
        tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h01, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h02, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 30'h03, 1'b1, 32'h4};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 30'h04, 1'b1, 32'h4};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 30'h05, 1'b1, 32'h4};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 30'h05, 1'b1, 32'h4};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h05, 1'b1, 32'h4};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 30'h06, 1'b1, 32'h8};
        tbl[9]  = '{1'b1, 32'h103, 1'b0, 1'b0, 30'h06, 1'b1, 32'h8};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h40, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h41, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h42, 1'b1, 32'h100};
        tbl[13] = '{1'b1, 32'h200, 1'b1, 1'b0, 30'h43, 1'b1, 32'h104};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h80, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h81, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 30'h82, 1'b1, 32'h200};

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        RSTN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; ID_READY = 1'b1;
        @(posedge CLK);
        #1;

        apply(1'b0, 1'b0, 32'h0, 1'b1);
        model_check();
        check("reset_re", 32'(IMEM_RE), 32'h0);
        check("reset_addr", 32'(IMEM_ADDR), 32'(RST_PC[31:2]));
        check("reset_valid", 32'(IF_VALID), 32'h0);
        check("reset_pc", IF_PC, 32'h0);
        check("reset_ir", IF_IR, 32'h0);
        advance();

        for (int i = 0; i < 17; i++) begin
            apply(1'b1, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            model_check();
            check($sformatf("tbl%0d_re", i), 32'(IMEM_RE), 32'(tbl[i].e_re));
            check($sformatf("tbl%0d_addr", i), 32'(IMEM_ADDR), 32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_valid", i), 32'(IF_VALID), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_pc", i), IF_PC, tbl[i].e_pc);
                check($sformatf("tbl%0d_ir", i), IF_IR, swap32(tbl[i].e_pc >> 2));
            end
            advance();
        end

        // build up 3 queued entries plus a read in flight, then reset over a redirect
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        apply(1'b0, 1'b1, 32'h400, 1'b1);
        model_check();
        advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1);
        model_check();
        check("midrst_valid", 32'(IF_VALID), 32'h0);
        check("midrst_re", 32'(IMEM_RE), 32'h0);
        check("midrst_addr", 32'(IMEM_ADDR), 32'(RST_PC[31:2]));
        advance();
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        apply(1'b1, 1'b0, 32'h0, 1'b1);
        model_check();
        check("restart_valid", 32'(IF_VALID), 32'h1);
        check("restart_pc", IF_PC, RST_PC);
        advance();

        // address wrap
        cyc(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 32'h0, 1'b1);
            model_check();
            if (IF_VALID) got.push_back(IF_PC);
            advance();
        end
        check("wrap_n", 32'(got.size()), 32'd6);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) check($sformatf("wrap_pc%0d", k), got[k], wrap_exp[k]);

        // endianness
        mem_const = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        apply(1'b1, 1'b0, 32'h0, 1'b1);
        model_check();
        check("be_ir", be_ir, 32'h1234_5678);
        check("le_ir", IF_IR, 32'h7856_3412);
        advance();
        mem_const = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic rs, rd, ry;
            rs = ($urandom_range(0, 199) != 0);
            rd = ($urandom_range(0, 19) == 0);
            ry = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
            cyc(rs, rd, $urandom, ry);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
